// File: rtl/alu_pkg.sv
// Shared types and constants for the arbitrated ALU block.
// State encoding, legal opcode range and default widths.
package alu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CW    = 5;
  localparam int CARD_MIN  = 1;
  localparam int CARD_MAX  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_HOLD
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: sixteen Card opcodes, carry/borrow via Cout.
// Subtractions use x + ~y + c, so Cout=1 means no borrow.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [CW-1:0]    Card,
  input  logic             Cin,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             Zero
);

  logic [WIDTH:0]   x;
  logic [WIDTH:0]   y;
  logic [WIDTH:0]   s;
  logic             c;
  logic             arith;
  logic [WIDTH-1:0] lf;

  always_comb begin
    x     = {1'b0, A};
    y     = '0;
    c     = 1'b0;
    arith = 1'b1;
    lf    = '0;
    case (Card)
      CW'(1):  y = {1'b0, B};
      CW'(2):  begin y = {1'b0, B}; c = Cin; end
      CW'(3):  begin y = {1'b0, ~B}; c = 1'b1; end
      CW'(4):  begin y = {1'b0, ~B}; c = ~Cin; end
      CW'(5):  begin x = {1'b0, B}; y = {1'b0, ~A}; c = 1'b1; end
      CW'(6):  begin x = {1'b0, B}; y = {1'b0, ~A}; c = ~Cin; end
      CW'(7):  begin arith = 1'b0; lf = A; end
      CW'(8):  begin arith = 1'b0; lf = B; end
      CW'(9):  begin arith = 1'b0; lf = ~A; end
      CW'(10): begin arith = 1'b0; lf = ~B; end
      CW'(11): begin arith = 1'b0; lf = A | B; end
      CW'(12): begin arith = 1'b0; lf = A & B; end
      CW'(13): begin arith = 1'b0; lf = A ^ B; end
      CW'(14): begin arith = 1'b0; lf = ~(A ^ B); end
      CW'(15): c = Cin;
      CW'(16): begin y = {1'b0, ~(WIDTH'(Cin))}; c = 1'b1; end
      default: arith = 1'b0;
    endcase
    s    = x + y + {{WIDTH{1'b0}}, c};
    F    = arith ? s[WIDTH-1:0] : lf;
    Cout = arith & s[WIDTH];
    Zero = (F == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU.
// One operation in flight: IDLE accepts, EXEC computes, HOLD presents.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [CW-1:0]    req0_card,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [CW-1:0]    req1_card,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic             last_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    card_q;
  logic             cin_q, id_q;
  logic             id_rq, cout_rq, zero_rq, err_rq;
  logic [WIDTH-1:0] f_rq;
  logic             g0, g1, acc, bad;
  logic [WIDTH-1:0] alu_f;
  logic             alu_c, alu_z;

  alu #(.WIDTH(WIDTH), .CW(CW)) u_alu (
    .A    (a_q),
    .B    (b_q),
    .Card (card_q),
    .Cin  (cin_q),
    .F    (alu_f),
    .Cout (alu_c),
    .Zero (alu_z)
  );

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        g0 = last_q;
        g1 = ~last_q;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
  end

  assign acc = g0 | g1;
  assign bad = (card_q < CW'(CARD_MIN)) || (card_q > CW'(CARD_MAX));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (acc) state_d = S_EXEC;
      S_EXEC:  state_d = S_HOLD;
      S_HOLD:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      card_q  <= '0;
      cin_q   <= 1'b0;
      id_q    <= 1'b0;
      id_rq   <= 1'b0;
      f_rq    <= '0;
      cout_rq <= 1'b0;
      zero_rq <= 1'b0;
      err_rq  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        last_q <= g1;
        id_q   <= g1;
        a_q    <= g1 ? req1_a    : req0_a;
        b_q    <= g1 ? req1_b    : req0_b;
        card_q <= g1 ? req1_card : req0_card;
        cin_q  <= g1 ? req1_cin  : req0_cin;
      end
      if (state_q == S_EXEC) begin
        id_rq   <= id_q;
        err_rq  <= bad;
        f_rq    <= bad ? '0 : alu_f;
        cout_rq <= bad ? 1'b0 : alu_c;
        zero_rq <= bad ? 1'b0 : alu_z;
      end
    end
  end

  assign req0_ready = g0;
  assign req1_ready = g1;
  assign rsp_valid  = (state_q == S_HOLD);
  assign rsp_id     = id_rq;
  assign rsp_f      = f_rq;
  assign rsp_cout   = cout_rq;
  assign rsp_zero   = zero_rq;
  assign rsp_err    = err_rq;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with hand-computed ALU results.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_arbiter;

  localparam logic [31:0] A0 = 32'hAAAAAAAA;
  localparam logic [31:0] B0 = 32'hCCCCCCCC;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic [31:0] req0_a, req0_b;
  logic [4:0]  req0_card;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req1_a, req1_b;
  logic [4:0]  req1_card;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_f;
  logic        rsp_cout, rsp_zero, rsp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] sw_f [16];
  logic        sw_c [16];

  alu_arbiter #(.WIDTH(32), .CW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_card  (req0_card),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_card  (req1_card),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_f      (rsp_f),
    .rsp_cout   (rsp_cout),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_rdy0", 64'(req0_ready), 64'd0);
    chk("rst_rdy1", 64'(req1_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_f", 64'(rsp_f), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Called on a falling edge in IDLE; returns on the falling edge
  // of the cycle after the response (IDLE again).
  task automatic op(input logic [1:0] vld, input logic [4:0] card,
                    input logic cin, input logic [31:0] a,
                    input logic [31:0] b, input logic eid,
                    input logic [31:0] ef, input logic ec,
                    input logic ez, input logic ee);
    req0_valid = vld[0];
    req1_valid = vld[1];
    req0_a = a; req0_b = b; req0_card = card; req0_cin = cin;
    req1_a = a; req1_b = b; req1_card = card; req1_cin = cin;
    #1;
    chk("grant0", 64'(req0_ready), 64'(eid == 1'b0));
    chk("grant1", 64'(req1_ready), 64'(eid == 1'b1));
    @(negedge clk);
    req0_a = ~a; req0_b = ~b; req0_cin = ~cin;
    req1_a = ~a; req1_b = ~b; req1_cin = ~cin;
    #1;
    chk("exec_rdy", 64'(req0_ready | req1_ready), 64'd0);
    chk("exec_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_id", 64'(rsp_id), 64'(eid));
    chk("rsp_f", 64'(rsp_f), 64'(ef));
    chk("rsp_cout", 64'(rsp_cout), 64'(ec));
    chk("rsp_zero", 64'(rsp_zero), 64'(ez));
    chk("rsp_err", 64'(rsp_err), 64'(ee));
    @(negedge clk);
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    sw_f = '{32'h77777776, 32'h77777776, 32'hDDDDDDDE, 32'hDDDDDDDE,
             32'h22222222, 32'h22222222, 32'hAAAAAAAA, 32'hCCCCCCCC,
             32'h55555555, 32'h33333333, 32'hEEEEEEEE, 32'h88888888,
             32'h66666666, 32'h99999999, 32'hAAAAAAAB, 32'hAAAAAAA9};
    sw_c = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_card = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_card = '0; req1_cin = 1'b0;
    @(negedge clk);
    do_reset();

    // single request straight out of reset
    op(2'b01, 5'd1, 1'b0, A0, B0, 1'b0, 32'h77777776, 1'b1, 1'b0, 1'b0);

    // tie from reset alternates starting with req0
    do_reset();
    op(2'b11, 5'd1, 1'b0, A0, B0, 1'b0, 32'h77777776, 1'b1, 1'b0, 1'b0);
    op(2'b11, 5'd3, 1'b0, A0, B0, 1'b1, 32'hDDDDDDDE, 1'b0, 1'b0, 1'b0);
    op(2'b11, 5'd5, 1'b0, A0, B0, 1'b0, 32'h22222222, 1'b1, 1'b0, 1'b0);
    op(2'b11, 5'd12, 1'b0, A0, B0, 1'b1, 32'h88888888, 1'b0, 1'b0, 1'b0);

    // illegal opcodes
    op(2'b10, 5'd0, 1'b0, A0, B0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    op(2'b10, 5'd17, 1'b0, A0, B0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);

    // opcode sweep
    for (int i = 0; i < 16; i++)
      op(2'b01, 5'(i + 1), (i >= 8), A0, B0, 1'b0, sw_f[i], sw_c[i],
         1'b0, 1'b0);

    // carry-in variants, zero flag and wrap-around
    op(2'b01, 5'd2, 1'b1, A0, B0, 1'b0, 32'h77777777, 1'b1, 1'b0, 1'b0);
    op(2'b01, 5'd4, 1'b1, A0, B0, 1'b0, 32'hDDDDDDDD, 1'b0, 1'b0, 1'b0);
    op(2'b01, 5'd3, 1'b0, 32'h12345678, 32'h12345678, 1'b0, 32'h0,
       1'b1, 1'b1, 1'b0);
    op(2'b01, 5'd15, 1'b1, 32'hFFFFFFFF, B0, 1'b0, 32'h0, 1'b1, 1'b1,
       1'b0);

    // backpressure in HOLD
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = A0; req0_b = B0; req0_card = 5'd13; req0_cin = 1'b0;
    #1;
    chk("bp_grant", 64'(req0_ready), 64'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_f", 64'(rsp_f), 64'h66666666);
      chk("bp_id", 64'(rsp_id), 64'd0);
      chk("bp_rdy", 64'(req0_ready | req1_ready), 64'd0);
    end
    @(negedge clk);
    chk("bp_last", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    op(2'b10, 5'd8, 1'b0, A0, B0, 1'b1, 32'hCCCCCCCC, 1'b0, 1'b0, 1'b0);

    // reset while the operation is in EXEC
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = A0; req0_b = B0; req0_card = 5'd1; req0_cin = 1'b0;
    #1;
    chk("mr_grant", 64'(req0_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_valid", 64'(rsp_valid), 64'd0);
    chk("mr_f", 64'(rsp_f), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mr_none", 64'(rsp_valid), 64'd0);
    end
    op(2'b11, 5'd11, 1'b0, A0, B0, 1'b0, 32'hEEEEEEEE, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
